rand_server: RTL and testbench
==============================

// Module: rand_server
// PURPOSE
//  Shares one 32-bit LFSR random source between N_REQ requesters. Round-robin arbitration;
//  per-request bounded draws in [0, LIMIT] via masked rejection sampling with a bounded retry
//  count. Sits between the LFSR core and MCU peripheral/game logic needing independent draws.
//  Supports runtime reseed.
// PARAMETERS
//  N_REQ      4            number of requesters (2..8)
//  DATA_W     8            width of each random result and limit
//  MAX_TRIES  4            rejection attempts before deterministic fallback (>=1)
// PORTS
//  CLK        in   1               system clock, 100 MHz, rising edge
//  RST        in   1               asynchronous, active-high reset
//  REQ        in   N_REQ           level request, one bit per requester
//  LIMIT      in   N_REQ*DATA_W    inclusive upper bound; requester i at [i*DATA_W +: DATA_W]
//  SEED_LD    in   1               one-cycle pulse: load SEED_IN into LFSR
//  SEED_IN    in   32              new seed value
//  GNT        out  N_REQ           one-hot, high one cycle with VALID; selects receiving requester
//  VALID      out  1               result valid, one-cycle pulse
//  RANDOM     out  DATA_W          bounded result; holds value until next VALID
//  BUSY       out  1               high in any state other than IDLE
// BEHAVIOUR
//  Reset: LFSR=SEED (32'h6B1CCA14); state IDLE; RR pointer=N_REQ-1 (requester 0 wins first);
//   GNT=0, VALID=0, RANDOM=0, BUSY=0, try count=0. All outputs registered.
//  LFSR: XNOR feedback, taps 32,22,2,1; shift left, feedback into bit 0. Steps only when
//   enabled (DRAW state); otherwise holds.
//  FSM IDLE -> DRAW -> DELIVER -> IDLE:
//   IDLE: if |REQ, pick first set bit searching from (ptr+1) mod N_REQ upward with wrap;
//    latch winner idx, lim=LIMIT[idx], mask=smallest 2^k-1 >= lim (lim=0 -> mask=0);
//    tries=0; -> DRAW. No REQ -> stay.
//   DRAW (1..MAX_TRIES cycles): s = lfsr[DATA_W-1:0] & mask; LFSR steps this cycle.
//    s<=lim -> result=s, -> DELIVER. s>lim and tries<MAX_TRIES-1 -> tries++, stay.
//    s>lim and tries==MAX_TRIES-1 -> result=s-(lim+1) (always <=lim since s<=2*lim+1),
//    -> DELIVER.
//   DELIVER: VALID=1, GNT=onehot(idx), RANDOM=result; ptr=idx; -> IDLE.
//  Latency: REQ sampled in IDLE at edge k -> VALID in cycle after edge k+1+retries;
//   min 2 cycles, max MAX_TRIES+1. Throughput: one result per 3 cycles min.
//  Handshake: requester consumes RANDOM when GNT[i]&VALID. REQ still high when IDLE next
//   samples it = new request (streaming allowed; RR still rotates among active requesters).
//   REQ dropped before winning: no effect, never granted. REQ not sampled outside IDLE.
//  LIMIT sampled only in IDLE at arbitration; later changes don't affect the in-flight draw.
//  lim = 2^DATA_W-1: mask all ones, first draw always accepted. lim=0: result 0, 1 LFSR step.
//  SEED_LD: highest priority, any state. LFSR<=SEED_IN (SEED_IN==all-ones, the XNOR lockup
//   state -> load SEED instead); in-flight draw aborted, no VALID/GNT, ptr unchanged, -> IDLE.
//   Aborted requester re-arbitrates if REQ still high.
//   SEED_LD same cycle as DELIVER: seed loads, VALID/GNT still emitted as scheduled.
//  RST mid-operation: immediate return to reset values; in-flight draw lost.
// STRUCTURE
//  rand_pkg: SEED constant, tap positions, state enum {IDLE,DRAW,DELIVER}, mask_of() function.
//  Sub-module lfsr32_core (CLK,RST,EN,LD,LD_VAL -> Q[31:0]); rand_server holds FSM, RR arbiter,
//   rejection logic. Arbiter stays inline (no separate module).
// TESTING
//  1 Reset: no REQ, 20 cycles -> VALID=0, GNT=0, RANDOM=0, BUSY=0, LFSR low byte 8'h14.
//  2 REQ=4'b0001, LIMIT0=255, 8 draws -> each RANDOM equals model LFSR low byte, exactly
//    one step per draw; VALID 2 cycles after REQ sampled.
//  3 REQ=4'b1111 held, all limits 255 -> GNT order 0001,0010,0100,1000,0001...
//    REQ=4'b0101 -> alternates 0001/0100.
//  4 LIMIT0=100, 10000 draws -> all RANDOM<=100; none exceed MAX_TRIES DRAW cycles; fallback
//    values match model. LIMIT0=0 -> RANDOM=0 every draw.
//  5 SEED_LD mid-DRAW with SEED_IN=32'h12345678 -> no VALID that draw; next result matches
//    model seeded 12345678. SEED_IN=32'hFFFFFFFF -> LFSR=6B1CCA14.
//  6 RST pulsed mid-DRAW, REQ held -> outputs 0 at once; after release requester 0 granted
//    first; result equals first post-reset draw of model.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared constants, FSM state type and bound-to-mask helper for rand_server.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rand_pkg;

  // Power-on / lockup-recovery seed for the 32-bit LFSR.
  localparam logic [31:0] SEED = 32'h6B1CCA14;

  // Bit positions of LFSR taps 32, 22, 2 and 1.
  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAW    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  // Smallest 2^k-1 that covers lim: smear the top set bit downwards.
  // lim = 0 gives 0.
  function automatic logic [31:0] mask_of(input logic [31:0] lim);
    logic [31:0] m;
    m = lim;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/lfsr32_core.sv
// 32-bit XNOR LFSR (taps 32,22,2,1), shift left with feedback into bit 0.
// Latency: Q reflects a step or load one cycle after EN/LD.
// Backpressure: holds its value whenever EN and LD are both low.
module lfsr32_core
  import rand_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        LD,
  input  logic [31:0] LD_VAL,
  output logic [31:0] Q
);

  logic fb;

  assign fb = ~(Q[TAP_A] ^ Q[TAP_B] ^ Q[TAP_C] ^ Q[TAP_D]);

  // Load beats step; all-ones is the XNOR lockup state, so substitute SEED.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q <= SEED;
    end else if (LD) begin
      Q <= (&LD_VAL) ? SEED : LD_VAL;
    end else if (EN) begin
      Q <= {Q[30:0], fb};
    end
  end

endmodule

// File: rtl/rand_server.sv
// Round-robin shares one LFSR among N_REQ requesters; bounded draws by masked rejection.
// Latency: VALID 2..MAX_TRIES+1 cycles after REQ is sampled in IDLE; one result per 3 cycles min.
// Backpressure: none; requester takes RANDOM on GNT[i]&VALID, held REQ re-arbitrates next IDLE.
module rand_server
  import rand_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_TRIES = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [N_REQ*DATA_W-1:0] LIMIT,
  input  logic                    SEED_LD,
  input  logic [31:0]             SEED_IN,
  output logic [N_REQ-1:0]        GNT,
  output logic                    VALID,
  output logic [DATA_W-1:0]       RANDOM,
  output logic                    BUSY
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  state_t            state;
  state_t            nxt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  win_idx;
  logic              win_vld;
  logic [DATA_W-1:0] lim_sel;
  logic [DATA_W-1:0] lim_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] samp;
  logic [DATA_W-1:0] res;
  logic [TRY_W-1:0]  tries_q;
  logic [31:0]       lfsr_q;
  logic              lfsr_en;
  logic              take;
  logic              bump;
  logic              deliver;
  logic              unused_lfsr_hi;

  lfsr32_core u_lfsr (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (lfsr_en),
    .LD     (SEED_LD),
    .LD_VAL (SEED_IN),
    .Q      (lfsr_q)
  );

  // Only the low DATA_W bits feed the draw.
  assign unused_lfsr_hi = ^lfsr_q[31:DATA_W];

  assign samp    = lfsr_q[DATA_W-1:0] & mask_q;
  assign lim_sel = LIMIT[int'(win_idx)*DATA_W +: DATA_W];

  // Round-robin pick: first set REQ bit searching upward from ptr+1 with wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      if (REQ[IDX_W'((int'(ptr) + off) % N_REQ)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'((int'(ptr) + off) % N_REQ);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next state and control strobes; a seed load aborts anything short of DELIVER.
  always_comb begin
    nxt     = state;
    lfsr_en = 1'b0;
    take    = 1'b0;
    bump    = 1'b0;
    deliver = 1'b0;
    res     = samp;
    case (state)
      IDLE: begin
        if (win_vld) begin
          take = 1'b1;
          nxt  = DRAW;
        end
      end
      DRAW: begin
        lfsr_en = 1'b1;
        if (samp <= lim_q) begin
          deliver = 1'b1;
          nxt     = DELIVER;
        end else if (tries_q == LAST_TRY) begin
          // samp <= 2*lim+1, so folding down by lim+1 stays in range.
          res     = samp - lim_q - DATA_W'(1);
          deliver = 1'b1;
          nxt     = DELIVER;
        end else begin
          bump = 1'b1;
        end
      end
      DELIVER: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (SEED_LD && (state != DELIVER)) begin
      nxt     = IDLE;
      take    = 1'b0;
      bump    = 1'b0;
      deliver = 1'b0;
    end
  end

  // Draw context capture, retry count and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr     <= IDX_W'(N_REQ - 1);
      idx_q   <= '0;
      lim_q   <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      GNT     <= '0;
      VALID   <= 1'b0;
      RANDOM  <= '0;
      BUSY    <= 1'b0;
    end else begin
      BUSY  <= (nxt != IDLE);
      VALID <= deliver;
      GNT   <= deliver ? (N_REQ'(1) << idx_q) : '0;
      if (take) begin
        idx_q   <= win_idx;
        lim_q   <= lim_sel;
        mask_q  <= DATA_W'(mask_of(32'(lim_sel)));
        tries_q <= '0;
      end else if (bump) begin
        tries_q <= tries_q + TRY_W'(1);
      end
      if (deliver) begin
        RANDOM <= res;
        ptr    <= idx_q;
      end
    end
  end

endmodule

// File: tb/tb_rand_server.sv
// Self-checking bench for rand_server: transaction-level model plus literal pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_rand_server;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MT = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] LIMIT;
  logic           SEED_LD;
  logic [31:0]    SEED_IN;
  logic [N-1:0]   GNT;
  logic           VALID;
  logic [W-1:0]   RANDOM;
  logic           BUSY;

  always #5 CLK = ~CLK;

  rand_server #(.N_REQ(N), .DATA_W(W), .MAX_TRIES(MT)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LIMIT(LIMIT), .SEED_LD(SEED_LD),
    .SEED_IN(SEED_IN), .GNT(GNT), .VALID(VALID), .RANDOM(RANDOM), .BUSY(BUSY)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic logic [31:0] lstep(input logic [31:0] x);
    return {x[30:0], ~(x[31] ^ x[21] ^ x[1] ^ x[0])};
  endfunction

  logic [31:0] m_lfsr;
  int          m_ptr, e, busy_last, free_edge, d_edge, p_idx;
  bit          pend;
  logic [W-1:0] p_res;
  logic [N-1:0] x_gnt;
  logic         x_valid, x_busy;
  logic [W-1:0] x_rand;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_lfsr = 32'h6B1CCA14; m_ptr = N - 1; e = 0; busy_last = -1; free_edge = 1;
      pend = 0; d_edge = 0; p_idx = 0; p_res = '0;
      x_gnt = '0; x_valid = 0; x_rand = '0; x_busy = 0;
    end else begin
      int idx, lim, m, s, res, n;
      e++;
      x_valid = 0;
      x_gnt   = '0;
      if (SEED_LD) begin
        if (pend && e <= d_edge) begin
          pend = 0; busy_last = e - 1; free_edge = e + 1;
        end
        m_lfsr = (SEED_IN == 32'hFFFFFFFF) ? 32'h6B1CCA14 : SEED_IN;
      end else if (e >= free_edge && REQ != '0) begin
        idx = -1;
        for (int i = 1; i <= N; i++)
          if (idx < 0 && REQ[(m_ptr + i) % N]) idx = (m_ptr + i) % N;
        lim = int'(LIMIT[idx*W +: W]);
        m = 0;
        while (m < lim) m = m * 2 + 1;
        n = 0; res = 0;
        for (int t = 0; t < MT; t++) begin
          s = int'(m_lfsr[W-1:0]) & m;
          m_lfsr = lstep(m_lfsr);
          n++;
          if (s <= lim) begin res = s; break; end
          if (t == MT - 1) res = s - (lim + 1);
        end
        pend = 1; d_edge = e + n; busy_last = d_edge; free_edge = d_edge + 2;
        p_idx = idx; p_res = res[W-1:0];
      end
      if (pend && e == d_edge) begin
        x_valid = 1; x_gnt = N'(1) << p_idx; x_rand = p_res; m_ptr = p_idx; pend = 0;
      end
      x_busy = (e <= busy_last);
    end
  end

  // ---------------- per-cycle compare ----------------
  int run = 0;
  always @(negedge CLK) begin
    if (chk_on && !RST) begin
      check("valid", 32'(VALID), 32'(x_valid));
      check("gnt", 32'(GNT), 32'(x_gnt));
      check("random", 32'(RANDOM), 32'(x_rand));
      check("busy", 32'(BUSY), 32'(x_busy));
      if (BUSY && !VALID) run++;
      else begin
        if (VALID) check("draw_cycles_le_max", 32'(run <= MT), 32'd1);
        run = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_valid(output logic [N-1:0] g, output logic [W-1:0] r, output int cyc);
    bit got;
    got = 0; g = '0; r = '0; cyc = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge CLK);
      if (VALID) begin got = 1; g = GNT; r = RANDOM; cyc = i + 1; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL wait_valid: no VALID within 60 cycles, got 0 expected 1");
    end
  endtask

  task automatic wait_draw();
    bit got;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge CLK);
      if (BUSY && !VALID) got = 1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL wait_draw: no DRAW cycle within 60 cycles, got 0 expected 1");
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  logic [N-1:0] g;
  logic [W-1:0] r;
  int           cyc;
  logic [N-1:0] ord_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] ord_b [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};

  initial begin
    RST = 1'b1; REQ = '0; LIMIT = '0; SEED_LD = 1'b0; SEED_IN = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk_on = 1;

    // Reset state held with no requests.
    repeat (20) @(negedge CLK);
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_gnt", 32'(GNT), 32'd0);
    check("rst_random", 32'(RANDOM), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);

    // Single requester, full-range limit: raw LFSR bytes, one step per draw.
    LIMIT = {N{8'd255}};
    REQ = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      wait_valid(g, r, cyc);
      check("t2_gnt", 32'(g), 32'h1);
      if (i == 0) check("t2_latency", 32'(cyc), 32'd2);
      if (i == 0) check("t2_first", 32'(r), 32'h14);
      if (i == 1) check("t2_second", 32'(r), 32'h29);
    end
    REQ = '0;
    do_reset();

    // Round-robin order.
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_valid(g, r, cyc);
      check("t3_rr_all", 32'(g), 32'(ord_a[i]));
    end
    REQ = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_valid(g, r, cyc);
      check("t3_rr_0101", 32'(g), 32'(ord_b[i]));
    end

    // Bounded draws with rejection and fallback.
    REQ = 4'b0001;
    LIMIT[7:0] = 8'd100;
    for (int i = 0; i < 10000; i++) begin
      wait_valid(g, r, cyc);
      check("t4_bound100", 32'(r <= 8'd100), 32'd1);
    end
    LIMIT[7:0] = 8'd0;
    for (int i = 0; i < 20; i++) begin
      wait_valid(g, r, cyc);
      check("t4_lim0", 32'(r), 32'd0);
    end

    // Random traffic: requests, limits and occasional reseeds.
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      REQ = N'($urandom);
      for (int j = 0; j < N; j++) begin
        case ($urandom_range(0, 3))
          0: LIMIT[j*W +: W] = 8'd0;
          1: LIMIT[j*W +: W] = 8'd255;
          default: LIMIT[j*W +: W] = W'($urandom);
        endcase
      end
      SEED_LD = ($urandom_range(0, 19) == 0);
      SEED_IN = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
    end
    @(negedge CLK);
    SEED_LD = 1'b0;
    REQ = '0;
    repeat (8) @(negedge CLK);

    // Reseed mid-draw aborts it; all-ones load falls back to SEED.
    LIMIT = {N{8'd255}};
    REQ = 4'b0001;
    wait_draw();
    SEED_LD = 1'b1; SEED_IN = 32'h12345678;
    @(negedge CLK);
    SEED_LD = 1'b0;
    wait_valid(g, r, cyc);
    check("t5_seed_12345678", 32'(r), 32'h78);
    wait_draw();
    SEED_LD = 1'b1; SEED_IN = 32'hFFFFFFFF;
    @(negedge CLK);
    SEED_LD = 1'b0;
    wait_valid(g, r, cyc);
    check("t5_seed_lockup", 32'(r), 32'h14);

    // Reset mid-draw.
    REQ = 4'b0101;
    wait_draw();
    #2 RST = 1'b1;
    #1;
    check("t6_valid", 32'(VALID), 32'd0);
    check("t6_gnt", 32'(GNT), 32'd0);
    check("t6_random", 32'(RANDOM), 32'd0);
    check("t6_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    wait_valid(g, r, cyc);
    check("t6_first_gnt", 32'(g), 32'h1);
    check("t6_first_val", 32'(r), 32'h14);

    REQ = '0;
    repeat (5) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
